// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Shares the single-port data RAM between port A (CPU load/store unit) and
//   port B (loader/DMA/debug). A three-state FSM (IDLE -> ACCESS -> ACK) serves
//   one request at a time: the grant is taken in IDLE, the RAM is driven for
//   exactly one ACCESS cycle, and ack_x pulses in ACK. Read data from the
//   combinational RAM output is registered into rdata_x at the end of ACCESS.
//
//   Configuration macro: RAM_ARB_FIXED_PRIO_EN
//     defined   : port A always wins a tie (B may starve)
//     undefined : round-robin tie break on last_grant (default)
//
// Parameters
//   mem_depth  RAM word count; address width AW = $clog2(mem_depth)
//   size       data word width
// Ports
//   clock, reset               system clock (rising), async active-high reset
//   req_x, we_x, addr_x,       port x request, write enable, word address,
//   wdata_x                    write data (x = a, b)
//   ack_x, rdata_x             one-cycle completion pulse, registered read data
//   ram_data, ram_wren,        RAM write data / write enable /
//   ram_wread, ram_address     read enable / address (zero outside ACCESS)
//   ram_salida                 RAM read data (combinational)
//   busy                       high in ACCESS or ACK
//   owner                      0=A, 1=B; requester of the current or last grant
module ram_arbiter #(
  parameter int mem_depth = 1024,
  parameter int size      = 32
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         req_a,
  input  logic                         we_a,
  input  logic [$clog2(mem_depth)-1:0] addr_a,
  input  logic [size-1:0]              wdata_a,
  output logic                         ack_a,
  output logic [size-1:0]              rdata_a,
  input  logic                         req_b,
  input  logic                         we_b,
  input  logic [$clog2(mem_depth)-1:0] addr_b,
  input  logic [size-1:0]              wdata_b,
  output logic                         ack_b,
  output logic [size-1:0]              rdata_b,
  output logic [size-1:0]              ram_data,
  output logic                         ram_wren,
  output logic                         ram_wread,
  output logic [$clog2(mem_depth)-1:0] ram_address,
  input  logic [size-1:0]              ram_salida,
  output logic                         busy,
  output logic                         owner
);

  localparam int AW = $clog2(mem_depth);

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

  state_t          state;
  logic            last_grant;
  logic            pick_b;
  logic            sel_we;
  logic [AW-1:0]   sel_addr;
  logic [size-1:0] sel_wdata;

  // Winner selection for the IDLE cycle; A is the default when only A or
  // neither requests.
  always_comb begin
    pick_b = 1'b0;
`ifdef RAM_ARB_FIXED_PRIO_EN
    pick_b = req_b && !req_a;
`else
    pick_b = req_b && (!req_a || !last_grant);
`endif
    sel_we    = pick_b ? we_b    : we_a;
    sel_addr  = pick_b ? addr_b  : addr_a;
    sel_wdata = pick_b ? wdata_b : wdata_a;
  end

  // The registered RAM pins double as the latched request: they are loaded
  // on the grant and cleared when ACCESS ends, so the async reset also drops
  // ram_wren immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      owner       <= 1'b0;
      busy        <= 1'b0;
      ack_a       <= 1'b0;
      ack_b       <= 1'b0;
      rdata_a     <= '0;
      rdata_b     <= '0;
      ram_data    <= '0;
      ram_wren    <= 1'b0;
      ram_wread   <= 1'b0;
      ram_address <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_a || req_b) begin
            owner       <= pick_b;
            last_grant  <= pick_b;
            ram_wren    <= sel_we;
            ram_wread   <= !sel_we;
            ram_address <= sel_addr;
            ram_data    <= sel_we ? sel_wdata : '0;
            busy        <= 1'b1;
            state       <= ACCESS;
          end
        end
        ACCESS: begin
          if (ram_wread) begin
            if (owner) rdata_b <= ram_salida;
            else       rdata_a <= ram_salida;
          end
          ram_wren    <= 1'b0;
          ram_wread   <= 1'b0;
          ram_address <= '0;
          ram_data    <= '0;
          ack_a       <= !owner;
          ack_b       <= owner;
          state       <= ACK;
        end
        ACK: begin
          ack_a <= 1'b0;
          ack_b <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
//   Directed bench for ram_arbiter with a behavioural 1024x32 RAM attached to
//   the ram_* pins. Expected values are hand-computed constants.
module tb_ram_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_a = 1'b0, we_a = 1'b0;
  logic [9:0]  addr_a = '0;
  logic [31:0] wdata_a = '0;
  logic        ack_a;
  logic [31:0] rdata_a;
  logic        req_b = 1'b0, we_b = 1'b0;
  logic [9:0]  addr_b = '0;
  logic [31:0] wdata_b = '0;
  logic        ack_b;
  logic [31:0] rdata_b;
  logic [31:0] ram_data;
  logic        ram_wren, ram_wread;
  logic [9:0]  ram_address;
  logic [31:0] ram_salida;
  logic        busy, owner;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef RAM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  ram_arbiter #(.mem_depth(1024), .size(32)) dut (
    .clock(clock), .reset(reset),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .ack_a(ack_a), .rdata_a(rdata_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .ack_b(ack_b), .rdata_b(rdata_b),
    .ram_data(ram_data), .ram_wren(ram_wren), .ram_wread(ram_wread),
    .ram_address(ram_address), .ram_salida(ram_salida),
    .busy(busy), .owner(owner)
  );

  always #5 clock = ~clock;

  // Behavioural RAM: synchronous write, combinational read gated by wread.
  logic [31:0] mem [0:1023];
  logic        pl_en = 1'b0;
  logic [9:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;

  always @(posedge clock) begin
    if (ram_wren) mem[ram_address] <= ram_data;
    if (pl_en)    mem[pl_addr]     <= pl_data;
  end
  assign ram_salida = ram_wread ? mem[ram_address] : '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic preload(input logic [9:0] a, input logic [31:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    step();
    pl_en = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ack_a"},   {31'd0, ack_a},     32'd0);
    check({tag, "_ack_b"},   {31'd0, ack_b},     32'd0);
    check({tag, "_rdata_a"}, rdata_a,            32'd0);
    check({tag, "_rdata_b"}, rdata_b,            32'd0);
    check({tag, "_wren"},    {31'd0, ram_wren},  32'd0);
    check({tag, "_wread"},   {31'd0, ram_wread}, 32'd0);
    check({tag, "_addr"},    {22'd0, ram_address}, 32'd0);
    check({tag, "_data"},    ram_data,           32'd0);
    check({tag, "_busy"},    {31'd0, busy},      32'd0);
    check({tag, "_owner"},   {31'd0, owner},     32'd0);
  endtask

  initial begin
    logic exp_b;
    int   g;

    // Reset with RAM preload.
    preload(10'd7,    32'h7777_7777);
    preload(10'd1023, 32'hCAFE_F00D);
    check_all_zero("rst");
    reset = 1'b0;

    // 1: single A write addr 5.
    req_a = 1'b1; we_a = 1'b1; addr_a = 10'd5; wdata_a = 32'hDEAD_BEEF;
    step();
    check("t1_wren",  {31'd0, ram_wren},  32'd1);
    check("t1_wread", {31'd0, ram_wread}, 32'd0);
    check("t1_addr",  {22'd0, ram_address}, 32'd5);
    check("t1_data",  ram_data, 32'hDEAD_BEEF);
    check("t1_busy",  {31'd0, busy}, 32'd1);
    check("t1_noack", {31'd0, ack_a}, 32'd0);
    step();
    check("t1_ack_a", {31'd0, ack_a}, 32'd1);
    check("t1_ack_b", {31'd0, ack_b}, 32'd0);
    check("t1_wren_off", {31'd0, ram_wren}, 32'd0);
    req_a = 1'b0; we_a = 1'b0;
    step();
    check("t1_ack_end", {31'd0, ack_a}, 32'd0);
    check("t1_idle",    {31'd0, busy},  32'd0);
    check("t1_mem5",    mem[5], 32'hDEAD_BEEF);

    // 2: B read addr 5.
    req_b = 1'b1; we_b = 1'b0; addr_b = 10'd5;
    step();
    check("t2_wread", {31'd0, ram_wread}, 32'd1);
    check("t2_wren",  {31'd0, ram_wren},  32'd0);
    check("t2_addr",  {22'd0, ram_address}, 32'd5);
    check("t2_owner", {31'd0, owner}, 32'd1);
    step();
    check("t2_ack_b",   {31'd0, ack_b}, 32'd1);
    check("t2_ack_a",   {31'd0, ack_a}, 32'd0);
    check("t2_rdata_b", rdata_b, 32'hDEAD_BEEF);
    check("t2_rdata_a", rdata_a, 32'd0);
    req_b = 1'b0;
    step();

    // 3: continuous tie after a fresh reset.
    reset = 1'b1;
    step();
    reset = 1'b0;
    req_a = 1'b1; we_a = 1'b1; addr_a = 10'd20; wdata_a = 32'hAAAA_0001;
    req_b = 1'b1; we_b = 1'b1; addr_b = 10'd21; wdata_b = 32'hBBBB_0002;
    for (int k = 1; k <= 12; k++) begin
      step();
      g = (k - 2) / 3;
      exp_b = FIXED ? 1'b0 : g[0];
      if (k % 3 == 2) begin
        check("t3_ack_a", {31'd0, ack_a}, {31'd0, !exp_b});
        check("t3_ack_b", {31'd0, ack_b}, {31'd0, exp_b});
        check("t3_owner", {31'd0, owner}, {31'd0, exp_b});
      end else begin
        check("t3_ack_a_idle", {31'd0, ack_a}, 32'd0);
        check("t3_ack_b_idle", {31'd0, ack_b}, 32'd0);
      end
      if (k == 11) begin
        req_a = 1'b0; req_b = 1'b0; we_a = 1'b0; we_b = 1'b0;
      end
    end
    check("t3_mem20", mem[20], 32'hAAAA_0001);

    // 4: A read top address, then A write addr 0 back-to-back.
    req_a = 1'b1; we_a = 1'b0; addr_a = 10'd1023;
    step();
    check("t4_addr_top", {22'd0, ram_address}, 32'd1023);
    check("t4_excl_rd",  {31'd0, ram_wread & ram_wren}, 32'd0);
    step();
    check("t4_ack_rd",   {31'd0, ack_a}, 32'd1);
    check("t4_rdata_top", rdata_a, 32'hCAFE_F00D);
    we_a = 1'b1; addr_a = 10'd0; wdata_a = 32'h0000_0BAD;
    step();
    check("t4_idle_wren", {31'd0, ram_wren}, 32'd0);
    step();
    check("t4_wren",     {31'd0, ram_wren},  32'd1);
    check("t4_excl_wr",  {31'd0, ram_wread & ram_wren}, 32'd0);
    check("t4_addr_0",   {22'd0, ram_address}, 32'd0);
    step();
    check("t4_ack_wr",   {31'd0, ack_a}, 32'd1);
    check("t4_rdata_hold", rdata_a, 32'hCAFE_F00D);
    req_a = 1'b0; we_a = 1'b0;
    step();
    check("t4_mem0",    mem[0],    32'h0000_0BAD);
    check("t4_mem1023", mem[1023], 32'hCAFE_F00D);

    // 5: reset during the ACCESS cycle of a B write.
    req_b = 1'b1; we_b = 1'b1; addr_b = 10'd7; wdata_b = 32'h0000_1234;
    step();
    check("t5_access", {31'd0, ram_wren}, 32'd1);
    reset = 1'b1;
    #1;
    check_all_zero("t5_rst_now");
    step();
    check_all_zero("t5_rst_edge");
    req_b = 1'b0; we_b = 1'b0;
    reset = 1'b0;
    check("t5_mem7_kept", mem[7], 32'h7777_7777);
    step();
    check("t5_no_ack", {31'd0, ack_b}, 32'd0);
    req_b = 1'b1; we_b = 1'b1;
    step();
    check("t5_retry_wren", {31'd0, ram_wren}, 32'd1);
    step();
    check("t5_retry_ack", {31'd0, ack_b}, 32'd1);
    req_b = 1'b0; we_b = 1'b0;
    step();
    check("t5_mem7_new", mem[7], 32'h0000_1234);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
